// File: rtl/sdram_burst_reader_if.sv
// Signal bundle for sdram_burst_reader: command/status, Avalon-MM burst read port
// and the FWFT output stream. master = the reader, slave = its environment.
interface sdram_burst_reader_if #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [LEN_W-1:0]  num_words;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic [7:0]        avm_burstcount;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    input  start, start_addr, num_words, abort,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready,
    output busy, done, avm_address, avm_burstcount, avm_read, out_valid, out_data
  );

  modport slave (
    output start, start_addr, num_words, abort,
    output avm_waitrequest, avm_readdata, avm_readdatavalid, out_ready,
    input  busy, done, avm_address, avm_burstcount, avm_read, out_valid, out_data
  );
endinterface

// File: rtl/sdram_burst_reader.sv
// Avalon-MM burst read master feeding an FWFT FIFO; bursts are issued only when the
// FIFO has room for every beat already requested plus the new burst.
//
// state   | meaning
// S_IDLE  | waiting for start; zero-length starts pulse done without traffic
// S_ISSUE | issuing bursts of min(BURST_LEN, req_left) as credits allow
// S_WAIT  | all bursts issued, collecting remaining beats
// S_FLUSH | aborted: finish a stalled request, drop beats until none outstanding
module sdram_burst_reader #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sdram_burst_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  req_left;
  logic [LEN_W-1:0]  rx_left;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  credit;
  logic [7:0]        bc;
  logic              pend_q;
  logic              done_zero_q;
  logic              credit_ok;
  logic              rd_c;
  logic              accept;
  logic              abort_take;
  logic              done_c;
  logic              start_take;
  logic              discard;
  logic              push;
  logic              pop;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;

  assign bc = (req_left >= LEN_W'(BURST_LEN)) ? 8'(BURST_LEN) : req_left[7:0];

  // FIFO slots not yet spoken for by data already buffered or still in flight
  assign credit    = CNT_W'(FIFO_DEPTH) - fifo_count - outstanding;
  assign credit_ok = credit >= CNT_W'(bc);

  assign start_take = (state == S_IDLE) && bus.start;
  assign accept     = rd_c && !bus.avm_waitrequest;
  assign discard    = (state == S_FLUSH) || abort_take;
  assign push       = bus.avm_readdatavalid && !discard;
  assign pop        = bus.out_valid && bus.out_ready;

  always_comb begin
    state_nx   = state;
    rd_c       = 1'b0;
    abort_take = 1'b0;
    done_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && (bus.num_words != '0)) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        // a request already stalled by waitrequest must stay up until accepted
        rd_c = pend_q || credit_ok;
        if (bus.abort) begin
          abort_take = 1'b1;
          state_nx   = S_FLUSH;
        end else if (rd_c && !bus.avm_waitrequest && (req_left == LEN_W'(bc))) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rx_left == '0) begin
          done_c   = 1'b1;
          state_nx = S_IDLE;
        end else if (bus.abort) begin
          abort_take = 1'b1;
          state_nx   = S_FLUSH;
        end
      end
      S_FLUSH: begin
        rd_c = pend_q;
        if (!pend_q && (outstanding == '0)) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      req_left    <= '0;
      rx_left     <= '0;
      outstanding <= '0;
      pend_q      <= 1'b0;
      done_zero_q <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_q      <= rd_c && bus.avm_waitrequest;
      done_zero_q <= start_take && (bus.num_words == '0);
      if (start_take) begin
        addr_q   <= bus.start_addr;
        req_left <= bus.num_words;
      end else if (accept) begin
        addr_q   <= addr_q + ADDR_W'(bc);
        req_left <= req_left - LEN_W'(bc);
      end
      if (start_take) begin
        rx_left <= bus.num_words;
      end else if (push && (rx_left != '0)) begin
        rx_left <= rx_left - LEN_W'(1);
      end
      // a burst accepted and a beat returned in the same cycle net out here
      outstanding <= outstanding + (accept ? CNT_W'(bc) : '0)
                     - CNT_W'(bus.avm_readdatavalid);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort_take) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      assert (!(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.avm_readdata;
  end

  assign bus.busy           = (state != S_IDLE);
  assign bus.done           = done_zero_q || done_c;
  assign bus.avm_read       = rd_c;
  assign bus.avm_address    = addr_q;
  assign bus.avm_burstcount = rd_c ? bc : 8'd0;
  assign bus.out_valid      = (fifo_count != '0);
  assign bus.out_data       = bus.out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_sdram_burst_reader.sv
// Directed and randomized bench for sdram_burst_reader against an SDRAM slave model
// whose contents are a fixed function of the word address.
`timescale 1ns/1ps
module tb_sdram_burst_reader;
  localparam int ADDR_W     = 29;
  localparam int DATA_W     = 64;
  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 32;
  localparam int LEN_W      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  sdram_burst_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // environment knobs, written only by the stimulus block
  int wr_pct  = 0;
  int gap_pct = 0;
  int rdy_pct = 100;
  bit wr_force = 1'b0;
  bit beat_en  = 1'b1;

  // environment state, written only by the slave/consumer block
  int                ncyc = 0;
  logic [ADDR_W-1:0] beat_q[$];
  logic [ADDR_W-1:0] req_addr_q[$];
  int                req_bc_q[$];
  logic [DATA_W-1:0] got_q[$];
  int                done_cnt = 0;
  int                done_cyc = 0;
  int                last_beat_cyc = 0;
  int                beats_sent = 0;
  int                read_cyc = 0;
  int                stab_err = 0;
  bit                stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_addr = '0;
  logic [7:0]        stall_bc = '0;

  function automatic logic [DATA_W-1:0] mem_word(logic [ADDR_W-1:0] a);
    return {3'b000, a, 32'(a) ^ 32'h5A5A_C3C3};
  endfunction

  // slave + consumer + monitor, all evaluated on the falling edge
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      beat_q.delete();
      stall_prev            = 1'b0;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
      bus.out_ready         = 1'b0;
    end else begin
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.done) begin
        done_cnt++;
        done_cyc = ncyc;
      end
      if (beat_en && (beat_q.size() > 0) && ($urandom_range(99) >= gap_pct)) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = mem_word(beat_q.pop_front());
        beats_sent++;
        last_beat_cyc = ncyc;
      end else begin
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = {$urandom(), $urandom()};
      end
      if (stall_prev && (!bus.avm_read || bus.avm_address !== stall_addr ||
                         bus.avm_burstcount !== stall_bc)) stab_err++;
      if (bus.avm_read) begin
        read_cyc++;
        bus.avm_waitrequest = wr_force || ($urandom_range(99) < wr_pct);
        if (bus.avm_waitrequest) begin
          stall_prev = 1'b1;
          stall_addr = bus.avm_address;
          stall_bc   = bus.avm_burstcount;
        end else begin
          stall_prev = 1'b0;
          req_addr_q.push_back(bus.avm_address);
          req_bc_q.push_back(int'(bus.avm_burstcount));
          for (int i = 0; i < int'(bus.avm_burstcount); i++)
            beat_q.push_back(bus.avm_address + ADDR_W'(i));
        end
      end else begin
        stall_prev          = 1'b0;
        bus.avm_waitrequest = wr_force;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chki(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int req_base, got_base, done_base, beat_base, read_base;

  task automatic launch(logic [ADDR_W-1:0] a, int n);
    req_base  = req_addr_q.size();
    got_base  = got_q.size();
    done_base = done_cnt;
    beat_base = beats_sent;
    read_base = read_cyc;
    bus.start_addr = a;
    bus.num_words  = LEN_W'(n);
    bus.start      = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic finish_check(string tag, logic [ADDR_W-1:0] a, int n);
    int budget;
    int rem;
    int nreq;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] exp_addr[$];
    int exp_bc[$];
    budget = 5000;
    while (done_cnt == done_base && budget > 0) begin
      step();
      budget--;
    end
    chki({tag, " done_seen"}, int'(budget > 0), 1);
    chki({tag, " done_latency"}, done_cyc - last_beat_cyc, 1);
    budget = 5000;
    while ((got_q.size() - got_base) < n && budget > 0) begin
      step();
      budget--;
    end
    step();
    step();
    chki({tag, " busy_after"}, int'(bus.busy), 0);
    chki({tag, " done_count"}, done_cnt - done_base, 1);
    chki({tag, " words"}, got_q.size() - got_base, n);
    for (int i = 0; i < n && (got_base + i) < got_q.size(); i++)
      chk($sformatf("%s word%0d", tag, i), got_q[got_base + i], mem_word(a + ADDR_W'(i)));
    ea  = a;
    rem = n;
    while (rem > 0) begin
      exp_addr.push_back(ea);
      exp_bc.push_back(rem < BURST_LEN ? rem : BURST_LEN);
      ea  += ADDR_W'(exp_bc[$]);
      rem -= exp_bc[$];
    end
    nreq = req_addr_q.size() - req_base;
    chki({tag, " bursts"}, nreq, exp_addr.size());
    for (int k = 0; k < exp_addr.size() && k < nreq; k++) begin
      chki($sformatf("%s burst%0d_addr", tag, k), int'(req_addr_q[req_base + k]), int'(exp_addr[k]));
      chki($sformatf("%s burst%0d_bc", tag, k), req_bc_q[req_base + k], exp_bc[k]);
    end
  endtask

  initial begin
    int budget;
    int sum;
    logic [ADDR_W-1:0] ra;
    int rn;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.start_addr = '0;
    bus.num_words  = '0;
    #1;
    chki("reset busy", int'(bus.busy), 0);
    chki("reset done", int'(bus.done), 0);
    chki("reset read", int'(bus.avm_read), 0);
    chki("reset addr", int'(bus.avm_address), 0);
    chki("reset bc", int'(bus.avm_burstcount), 0);
    chki("reset out_valid", int'(bus.out_valid), 0);
    chk("reset out_data", bus.out_data, 64'h0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // 20 words: bursts 8,8,4
    launch(29'h0000_0100, 20);
    finish_check("t1", 29'h0000_0100, 20);

    // first request stalled 5 cycles
    wr_force = 1'b1;
    launch(29'h0012_3400, 8);
    chki("t2 read_next_cycle", int'(bus.avm_read), 1);
    for (int i = 0; i < 5; i++) begin
      chki($sformatf("t2 hold%0d_read", i), int'(bus.avm_read), 1);
      chki($sformatf("t2 hold%0d_addr", i), int'(bus.avm_address), int'(29'h0012_3400));
      chki($sformatf("t2 hold%0d_bc", i), int'(bus.avm_burstcount), 8);
      step();
    end
    wr_force = 1'b0;
    finish_check("t2", 29'h0012_3400, 8);
    chki("t2 stability", stab_err, 0);

    // consumer stalled: at most FIFO_DEPTH words requested
    rdy_pct = 0;
    launch(29'h0000_4000, 64);
    repeat (150) step();
    sum = 0;
    for (int k = req_base; k < req_addr_q.size(); k++) sum += req_bc_q[k];
    chki("t3 requested_words", sum, FIFO_DEPTH);
    chki("t3 busy", int'(bus.busy), 1);
    chki("t3 out_valid", int'(bus.out_valid), 1);
    chki("t3 nothing_popped", got_q.size() - got_base, 0);
    rdy_pct = 100;
    finish_check("t3", 29'h0000_4000, 64);

    // zero-length transfer
    launch(29'h0000_0777, 0);
    chki("t4 done", int'(bus.done), 1);
    chki("t4 busy", int'(bus.busy), 0);
    step();
    chki("t4 done_end", int'(bus.done), 0);
    repeat (5) step();
    chki("t4 busy_after", int'(bus.busy), 0);
    chki("t4 no_read", read_cyc - read_base, 0);
    chki("t4 done_count", done_cnt - done_base, 1);

    // abort with 8 beats outstanding and a second burst stalled
    beat_en = 1'b0;
    launch(29'h0000_8000, 16);
    wr_force = 1'b1;
    budget = 20;
    while ((req_addr_q.size() - req_base) < 1 && budget > 0) begin
      step();
      budget--;
    end
    chki("t5 first_accepted", req_addr_q.size() - req_base, 1);
    step();
    chki("t5 stalled_read", int'(bus.avm_read), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chki($sformatf("t5 held%0d_read", i), int'(bus.avm_read), 1);
      chki($sformatf("t5 held%0d_addr", i), int'(bus.avm_address), int'(29'h0000_8008));
      chki($sformatf("t5 held%0d_bc", i), int'(bus.avm_burstcount), 8);
      chki($sformatf("t5 held%0d_busy", i), int'(bus.busy), 1);
      step();
    end
    wr_force = 1'b0;
    step();
    step();
    chki("t5 requests", req_addr_q.size() - req_base, 2);
    beat_en = 1'b1;
    budget = 200;
    while (bus.busy && budget > 0) begin
      step();
      budget--;
    end
    chki("t5 busy_fell", int'(bus.busy), 0);
    chki("t5 beats_returned", beats_sent - beat_base, 16);
    chki("t5 no_done", done_cnt - done_base, 0);
    chki("t5 nothing_delivered", got_q.size() - got_base, 0);
    chki("t5 fifo_empty", int'(bus.out_valid), 0);
    chki("t5 stability", stab_err, 0);

    // asynchronous reset mid-transfer, then a fresh transfer
    gap_pct = 30;
    launch(29'h0001_0000, 40);
    budget = 200;
    while ((beats_sent - beat_base) < 5 && budget > 0) begin
      step();
      budget--;
    end
    chki("t6 busy_before", int'(bus.busy), 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chki("t6 busy", int'(bus.busy), 0);
    chki("t6 done", int'(bus.done), 0);
    chki("t6 read", int'(bus.avm_read), 0);
    chki("t6 addr", int'(bus.avm_address), 0);
    chki("t6 bc", int'(bus.avm_burstcount), 0);
    chki("t6 out_valid", int'(bus.out_valid), 0);
    chk("t6 out_data", bus.out_data, 64'h0);
    repeat (3) step();
    rst_n = 1'b1;
    step();
    gap_pct = 0;
    launch(29'h0002_0005, 13);
    finish_check("t6 after", 29'h0002_0005, 13);

    // randomized transfers, first one wraps the address space
    for (int it = 0; it < 5; it++) begin
      ra = (it == 0) ? 29'h1FFF_FFFB : ADDR_W'($urandom());
      rn = $urandom_range(1, 70);
      wr_pct  = $urandom_range(0, 40);
      gap_pct = $urandom_range(0, 50);
      rdy_pct = $urandom_range(30, 100);
      launch(ra, rn);
      finish_check($sformatf("rand%0d", it), ra, rn);
    end
    chki("final stability", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
